// File: rtl/regdump_reader.sv
// Debug read-out engine: walks the register file through one combinational read
// port and streams each register as four little-endian bytes over valid/ready.
module regdump_reader #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t      state;
  state_t      state_next;
  logic [4:0]  idx;
  logic [31:0] shift;
  logic [1:0]  byte_cnt;

  logic beat_fire;
  logic reg_end;
  logic dump_end;

  assign beat_fire = (state == SEND) && out_ready;
  assign reg_end   = (byte_cnt == 2'd3);
  assign dump_end  = reg_end && (idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next; otherwise a latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (beat_fire && reg_end) state_next = dump_end ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The register is sampled only in LOAD, so later writes miss the current dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      shift    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) idx <= '0;
        LOAD: begin
          shift    <= rd_data;
          byte_cnt <= '0;
        end
        SEND: if (beat_fire) begin
          if (!reg_end) begin
            shift    <= shift >> 8;
            byte_cnt <= byte_cnt + 2'd1;
          end else if (!dump_end) begin
            idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so reset clears them without waiting for a clock.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      LOAD: begin
        busy    = 1'b1;
        rd_addr = idx;
      end
      SEND: begin
        busy      = 1'b1;
        rd_addr   = idx;
        out_valid = 1'b1;
        out_data  = shift[7:0];
        out_last  = dump_end;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regdump_reader.sv
// Randomized scoreboard bench for regdump_reader: expected bytes come from a
// snapshot of the register file model; a negedge monitor pops and compares beats.
module tb_regdump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;

  logic        start4;
  logic        busy4;
  logic        done4;
  logic [4:0]  rd_addr4;
  logic [31:0] rd_data4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic        out_last4;
  logic        out_ready4;

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  // Register file model: combinational read, x0 hardwired to zero.
  always_comb rd_data  = (rd_addr == 5'd0)  ? 32'd0 : regs[rd_addr];
  always_comb rd_data4 = (rd_addr4 == 5'd0) ? 32'd0 : regs[rd_addr4];
  assign out_ready4 = 1'b1;

  regdump_reader #(.NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  regdump_reader #(.NUM_REGS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .out_valid(out_valid4),
    .out_data(out_data4), .out_last(out_last4), .out_ready(out_ready4)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    t0 = 0;
  int    beats = 0;
  int    done_cnt = 0;
  int    done_rel = -1;
  int    rmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: 0 = always ready, 1 = random, 2 = stall cycles 29..31 of the dump.
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = !(((cyc - t0) >= 29) && ((cyc - t0) <= 31));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: a beat is accepted at the next posedge when valid and ready are both high here.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat actual=%h expected=none", out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check($sformatf("beat%0d_data", beats), 32'(out_data), 32'(e.data));
          check($sformatf("beat%0d_last", beats), 32'(out_last), 32'(e.last));
        end
        beats++;
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
    end
  end

  // Expected stream: each register's value at dump time, LSB first; ovr_idx models a planned pre-LOAD write.
  task automatic push_expected(input int n, input int ovr_idx, input logic [31:0] ovr_val);
    for (int k = 0; k < n; k++) begin
      logic [31:0] v;
      v = (k == 0) ? 32'd0 : ((k == ovr_idx) ? ovr_val : regs[k]);
      for (int b = 0; b < 4; b++) begin
        beat_t e;
        e.data = 8'((v >> (8 * b)) & 32'hFF);
        e.last = (k == n - 1) && (b == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_dump(input string tag, input int ready_mode, input bit pulses,
                          input bit writes, input int exp_done);
    int rel;
    beats    = 0;
    done_cnt = 0;
    done_rel = -1;
    exp_q.delete();
    push_expected(32, writes ? 20 : -1, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    rmode = ready_mode;
    t0    = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_cycle1"}, 32'(busy), 32'd1);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      rel = cyc - t0;
      if (pulses) start = (rel == 10) || (rel == 80) || (rel == 161);
      if (writes && rel == 30) regs[3] = 32'h11111111;
      if (writes && rel == 95) regs[20] = 32'hCAFEF00D;
      if (ready_mode == 2 && rel >= 29 && rel <= 31) begin
        check($sformatf("%s_stall_valid_c%0d", tag, rel), 32'(out_valid), 32'd1);
        check($sformatf("%s_stall_data_c%0d", tag, rel), 32'(out_data), 32'h00);
      end
      if (rel == exp_done) check({tag, "_busy_done_cycle"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done", tag);
    end
    if (exp_done >= 0) begin
      check({tag, "_done_cycle"}, 32'(done_rel), 32'(exp_done));
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    end
    check({tag, "_beats"}, 32'(beats), 32'd128);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_no_restart"}, 32'(beats), 32'd128);
    check({tag, "_single_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int vcount;
    int b4;
    int last4;
    int done4_rel;
    logic [31:0] v4;
    rst       = 1'b0;
    start     = 1'($urandom_range(0, 1));
    start4    = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[1] = 32'hDEADBEEF;

    // Reset asserted between clock edges must clear all outputs at once.
    #12;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("idle_no_valid", 32'(vcount), 32'd0);

    run_dump("full", 0, 1'b0, 1'b0, 161);
    run_dump("stall", 2, 1'b0, 1'b0, 164);
    run_dump("random_ready", 1, 1'b0, 1'b0, -1);
    run_dump("start_busy", 0, 1'b1, 1'b0, 161);
    run_dump("reg_write", 0, 1'b0, 1'b1, 161);
    regs[3]  = 32'h1000_0003;
    regs[20] = 32'h1000_0014;

    // Reset at beat 50 aborts the dump; no done may follow.
    beats    = 0;
    done_cnt = 0;
    exp_q.delete();
    push_expected(32, -1, 32'd0);
    rmode = 0;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 400 && beats < 50; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_reached_beat50", 32'(beats), 32'd50);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid_drop", 32'(out_valid), 32'd0);
    check("abort_last", 32'(out_last), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_dump("restart", 0, 1'b0, 1'b0, 161);

    // NUM_REGS=4 instance: 16 beats, last on beat 15, done in cycle 21.
    b4        = 0;
    last4     = -1;
    done4_rel = -1;
    @(posedge clk);
    #1;
    start4 = 1'b1;
    @(negedge clk);
    for (int rel = 1; rel <= 30; rel++) begin
      @(posedge clk);
      #1;
      start4 = 1'b0;
      @(negedge clk);
      if (out_valid4) begin
        v4 = (b4 / 4 == 0) ? 32'd0 : regs[b4 / 4];
        check($sformatf("n4_beat%0d_data", b4), 32'(out_data4), (v4 >> (8 * (b4 % 4))) & 32'hFF);
        if (out_last4) last4 = b4;
        b4++;
      end
      if (done4) done4_rel = rel;
    end
    check("n4_beats", 32'(b4), 32'd16);
    check("n4_last_beat", 32'(last4), 32'd15);
    check("n4_done_cycle", 32'(done4_rel), 32'd21);
    check("n4_idle_after", 32'(busy4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
